// File: rtl/sys_cmd_sequencer_if.sv
// Command / serial-link / response bundle for sys_cmd_sequencer.
// The sequencer uses the slave view; the host and link models use the master view.
interface sys_cmd_sequencer_if #(
  parameter int BUS_WIDTH = 8,
  parameter int Reg_Addr  = 4,
  parameter int ALU_FUN   = 4,
  parameter int TIMEOUT_W = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [Reg_Addr-1:0]    cmd_addr;
  logic [BUS_WIDTH-1:0]   cmd_data_a;
  logic [BUS_WIDTH-1:0]   cmd_data_b;
  logic [ALU_FUN-1:0]     cmd_fun;
  logic [TIMEOUT_W-1:0]   timeout_limit;
  logic [BUS_WIDTH-1:0]   tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [BUS_WIDTH-1:0]   rx_data;
  logic                   rx_valid;
  logic [2*BUS_WIDTH-1:0] rsp_data;
  logic                   rsp_valid;
  logic                   rsp_timeout;
  logic                   busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
           timeout_limit, tx_ready, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
           timeout_limit, tx_ready, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout, busy
  );
endinterface

// File: rtl/sys_cmd_sequencer.sv
// Host-side command sequencer: frames one command toward the UART transmitter,
// then gathers the response bytes into a 16-bit result or reports a timeout.
module sys_cmd_sequencer #(
  parameter int BUS_WIDTH = 8,
  parameter int Reg_Addr  = 4,
  parameter int ALU_FUN   = 4,
  parameter int TIMEOUT_W = 16
) (
  input logic                clk,
  input logic                rst,
  sys_cmd_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  localparam logic [1:0] OP_RF_WR   = 2'b00;
  localparam logic [1:0] OP_RF_RD   = 2'b01;
  localparam logic [1:0] OP_ALU_OP  = 2'b10;
  localparam logic [1:0] OP_ALU_NOP = 2'b11;

  logic [1:0]             state;
  logic [1:0]             op;
  logic [Reg_Addr-1:0]    addr;
  logic [BUS_WIDTH-1:0]   data_a;
  logic [BUS_WIDTH-1:0]   data_b;
  logic [ALU_FUN-1:0]     fun;
  logic [1:0]             byte_idx;
  logic                   rx_cnt;
  logic [BUS_WIDTH-1:0]   rx_lo;
  logic [TIMEOUT_W-1:0]   tcnt;
  logic [2*BUS_WIDTH-1:0] rsp_data;
  logic                   rsp_valid;
  logic                   rsp_timeout;

  logic [BUS_WIDTH-1:0]   frame_byte;
  logic [1:0]             last_idx;
  logic [TIMEOUT_W-1:0]   tcnt_next;

  // Frame contents are selected from the latched command, so the offered byte
  // cannot move while the transmitter is stalling.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned infers a latch.
    frame_byte = '0;
    last_idx   = 2'd1;
    case (op)
      OP_RF_WR: begin
        last_idx = 2'd2;
        case (byte_idx)
          2'd0:    frame_byte = BUS_WIDTH'(8'hAA);
          2'd1:    frame_byte = BUS_WIDTH'(addr);
          default: frame_byte = data_a;
        endcase
      end
      OP_RF_RD: begin
        frame_byte = (byte_idx == 2'd0) ? BUS_WIDTH'(8'hBB) : BUS_WIDTH'(addr);
      end
      OP_ALU_OP: begin
        last_idx = 2'd3;
        case (byte_idx)
          2'd0:    frame_byte = BUS_WIDTH'(8'hCC);
          2'd1:    frame_byte = data_a;
          2'd2:    frame_byte = data_b;
          default: frame_byte = BUS_WIDTH'(fun);
        endcase
      end
      default: begin
        frame_byte = (byte_idx == 2'd0) ? BUS_WIDTH'(8'hDD) : BUS_WIDTH'(fun);
      end
    endcase
  end

  // Saturating so a long silence with a large limit can never wrap back to zero.
  assign tcnt_next = (tcnt == '1) ? tcnt : tcnt + TIMEOUT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op          <= OP_RF_WR;
      addr        <= '0;
      data_a      <= '0;
      data_b      <= '0;
      fun         <= '0;
      byte_idx    <= '0;
      rx_cnt      <= 1'b0;
      rx_lo       <= '0;
      tcnt        <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op       <= bus.cmd_op;
            addr     <= bus.cmd_addr;
            data_a   <= bus.cmd_data_a;
            data_b   <= bus.cmd_data_b;
            fun      <= bus.cmd_fun;
            byte_idx <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            if (byte_idx == last_idx) begin
              if (op == OP_RF_WR) begin
                rsp_data  <= '0;
                rsp_valid <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                rx_cnt <= 1'b0;
                tcnt   <= '0;
                state  <= ST_WAIT_RSP;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (bus.rx_valid) begin
            tcnt <= '0;
            if (op == OP_RF_RD) begin
              rsp_data  <= {{BUS_WIDTH{1'b0}}, bus.rx_data};
              rsp_valid <= 1'b1;
              state     <= ST_IDLE;
            end else if (!rx_cnt) begin
              rx_lo  <= bus.rx_data;
              rx_cnt <= 1'b1;
            end else begin
              rsp_data  <= {bus.rx_data, rx_lo};
              rsp_valid <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            tcnt <= tcnt_next;
            // The limit is reached on the edge where the count first equals it.
            if ((bus.timeout_limit != '0) && (tcnt_next == bus.timeout_limit)) begin
              rsp_timeout <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.tx_valid    = (state == ST_SEND);
  assign bus.tx_data     = (state == ST_SEND) ? frame_byte : '0;
  assign bus.rsp_data    = rsp_data;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_timeout = rsp_timeout;

endmodule

// File: tb/tb_sys_cmd_sequencer.sv
// Directed bench for sys_cmd_sequencer: expected frame bytes and responses are
// queued when each command is issued and compared as the DUT produces them.
module tb_sys_cmd_sequencer;

  typedef struct packed {
    logic        is_timeout;
    logic [15:0] data;
  } rsp_t;

  logic clk;
  logic rst;

  sys_cmd_sequencer_if bus ();

  sys_cmd_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_q[$];
  rsp_t       rsp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cmd_edge = -1;
  int first_accept_edge = -1;
  int last_accept_edge = -1;
  int n_accept = 0;
  int rx_edge = -1;
  int rsp_edge = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_tx_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pre-edge: score any accepted TX byte. Post-edge: score any response pulse.
  task automatic tick();
    rsp_t e;
    logic [7:0] b;
    #1;
    if (bus.tx_valid) begin
      if (stall_prev) check("tx_stable", bus.tx_data, prev_tx_data);
      if (bus.tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", tx_q.size(), 1);
        else begin
          b = tx_q.pop_front();
          check("tx_byte", bus.tx_data, b);
        end
        if (n_accept == 0) first_accept_edge = cyc + 1;
        last_accept_edge = cyc + 1;
        n_accept++;
      end
    end
    stall_prev   = bus.tx_valid && !bus.tx_ready;
    prev_tx_data = bus.tx_data;
    if (bus.rx_valid) rx_edge = cyc + 1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.rsp_valid || bus.rsp_timeout) begin
      rsp_edge = cyc;
      check("rsp_exclusive", bus.rsp_valid & bus.rsp_timeout, 0);
      if (rsp_q.size() == 0) check("rsp_unexpected", rsp_q.size(), 1);
      else begin
        e = rsp_q.pop_front();
        check("rsp_kind_timeout", bus.rsp_timeout, e.is_timeout);
        check("rsp_data", bus.rsp_data, e.data);
      end
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [3:0] addr,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
    bus.cmd_op     = op;
    bus.cmd_addr   = addr;
    bus.cmd_data_a = a;
    bus.cmd_data_b = b;
    bus.cmd_fun    = fun;
    bus.cmd_valid  = 1'b1;
    n_accept = 0;
    first_accept_edge = -1;
    rsp_edge = -1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    tick();
    cmd_edge = cyc;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = ~op;
    bus.cmd_addr   = ~addr;
    bus.cmd_data_a = ~a;
    bus.cmd_data_b = ~b;
    bus.cmd_fun    = ~fun;
    check("cmd_ready_after", bus.cmd_ready, 0);
    check("busy_after_cmd", bus.busy, 1);
    check("tx_valid_after_cmd", bus.tx_valid, 1);
  endtask

  task automatic wait_tx_done(input int budget);
    for (int i = 0; i < budget && bus.tx_valid; i++) tick();
    check("tx_done_budget", bus.tx_valid, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check("idle_budget", bus.busy, 0);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = 2'b00;
    bus.cmd_addr      = '0;
    bus.cmd_data_a    = '0;
    bus.cmd_data_b    = '0;
    bus.cmd_fun       = '0;
    bus.timeout_limit = '0;
    bus.tx_ready      = 1'b1;
    bus.rx_data       = '0;
    bus.rx_valid      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // RF_WR addr 5 data 3C: three back-to-back bytes, completion right after.
    tx_q.push_back(8'hAA); tx_q.push_back(8'h05); tx_q.push_back(8'h3C);
    rsp_q.push_back({1'b0, 16'h0000});
    issue_cmd(2'b00, 4'd5, 8'h3C, 8'h00, 4'd0);
    wait_idle(10);
    check("wr_first_accept", first_accept_edge, cmd_edge + 1);
    check("wr_n_accept", n_accept, 3);
    check("wr_consecutive", last_accept_edge - first_accept_edge, 2);
    check("wr_rsp_timing", rsp_edge, last_accept_edge);

    // RF_RD addr 2; a strobe on the last-accept edge is dropped; real byte after 20 cycles.
    tx_q.push_back(8'hBB); tx_q.push_back(8'h02);
    rsp_q.push_back({1'b0, 16'h009A});
    issue_cmd(2'b01, 4'd2, 8'h00, 8'h00, 4'd0);
    tick();
    rx_byte(8'h55);
    check("rd_in_wait_busy", bus.busy, 1);
    check("rd_in_wait_tx", bus.tx_valid, 0);
    repeat (20) tick();
    check("rd_no_early_rsp", rsp_edge, -1);
    rx_byte(8'h9A);
    check("rd_rsp_timing", rsp_edge, rx_edge);
    check("rd_ready_after", bus.cmd_ready, 1);

    // ALU_OP with TX_READY toggling; response low byte first.
    tx_q.push_back(8'hCC); tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h00);
    rsp_q.push_back({1'b0, 16'h0046});
    issue_cmd(2'b10, 4'd0, 8'h12, 8'h34, 4'd0);
    for (int i = 0; i < 20 && bus.tx_valid; i++) begin
      bus.tx_ready = ~bus.tx_ready;
      tick();
    end
    check("alu_tx_done", bus.tx_valid, 0);
    check("alu_n_accept", n_accept, 4);
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    rx_byte(8'h46);
    repeat (4) tick();
    check("alu_half_no_rsp", rsp_edge, -1);
    rx_byte(8'h00);
    check("alu_rsp_timing", rsp_edge, rx_edge);

    // ALU_NOP with limit 10: one byte, then silence -> timeout, data held.
    bus.timeout_limit = 16'd10;
    tx_q.push_back(8'hDD); tx_q.push_back(8'h02);
    rsp_q.push_back({1'b1, 16'h0046});
    issue_cmd(2'b11, 4'd0, 8'h00, 8'h00, 4'd2);
    wait_tx_done(10);
    tick();
    rx_byte(8'h77);
    wait_idle(30);
    check("to_timing", rsp_edge, rx_edge + 10);
    check("to_data_held", bus.rsp_data, 16'h0046);
    bus.timeout_limit = '0;
    tick();

    // Reset during SEND of ALU_OP after two accepted bytes.
    tx_q.push_back(8'hCC); tx_q.push_back(8'hAB);
    issue_cmd(2'b10, 4'd0, 8'hAB, 8'hCD, 4'd5);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rsp_data", bus.rsp_data, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_timeout", bus.rsp_timeout, 0);
    tick();
    rst = 1'b0;
    check("mid_rst_txq_drained", tx_q.size(), 0);

    tx_q.push_back(8'hBB); tx_q.push_back(8'h07);
    rsp_q.push_back({1'b0, 16'h00E1});
    issue_cmd(2'b01, 4'd7, 8'h00, 8'h00, 4'd0);
    wait_tx_done(10);
    check("post_rst_first_accept", first_accept_edge, cmd_edge + 1);
    repeat (2) tick();
    rx_byte(8'hE1);
    check("post_rst_rsp_timing", rsp_edge, rx_edge);

    // RX strobes while idle must not produce any pulse.
    rsp_edge = -1;
    rx_byte(8'h11);
    repeat (3) tick();
    check("idle_rx_no_rsp", rsp_edge, -1);
    check("idle_rx_ready", bus.cmd_ready, 1);

    check("txq_empty", tx_q.size(), 0);
    check("rspq_empty", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sys_cmd_sequencer.md
# sys_cmd_sequencer

Host-side command sequencer upstream of the system's UART receive path. It accepts one command per handshake, serialises it into the system's frame format (opcode byte then operand bytes) toward a UART transmitter, then collects the response bytes coming back from the system's UART TX output. It returns them as one 16-bit result, or flags a timeout. Runs on a single clock; it feeds the serial link in front of the system controller and consumes what that link returns.

## Interface
- BUS_WIDTH, 8, byte width of frames and operands
- Reg_Addr, 4, register-file address width
- ALU_FUN, 4, ALU function code width
- TIMEOUT_W, 16, width of response timeout counter/limit

- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high only in IDLE
- CMD_OP  in  2  00 RF_WR, 01 RF_RD, 10 ALU_OP (with operands), 11 ALU_NOP (no operands)
- CMD_ADDR  in  Reg_Addr  register address
- CMD_DATA_A  in  BUS_WIDTH  write data (RF_WR) / operand A (ALU_OP)
- CMD_DATA_B  in  BUS_WIDTH  operand B (ALU_OP)
- CMD_FUN  in  ALU_FUN  ALU function
- TIMEOUT_LIMIT  in  TIMEOUT_W  idle cycles allowed between response bytes; 0 = wait forever
- TX_DATA  out  BUS_WIDTH  frame byte to UART transmitter
- TX_VALID  out  1  byte offered
- TX_READY  in  1  byte accepted when TX_VALID && TX_READY
- RX_DATA  in  BUS_WIDTH  response byte from UART receiver
- RX_VALID  in  1  one-cycle strobe per received byte
- RSP_DATA  out  2*BUS_WIDTH  result
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_TIMEOUT  out  1  one-cycle timeout pulse
- BUSY  out  1  high whenever state != IDLE

## Operation
- States: IDLE, SEND, WAIT_RSP.
- IDLE: CMD_READY=1. On CMD_VALID, all CMD_* fields are registered and the state goes to SEND with byte index 0. CMD_* inputs are ignored thereafter.
- Frames (byte 0 first). Address and function are zero-extended to BUS_WIDTH.
  - RF_WR: AA, addr, data_A (3 bytes, 0 response bytes)
  - RF_RD: BB, addr (2 bytes, 1 response byte)
  - ALU_OP: CC, data_A, data_B, fun (4 bytes, 2 response bytes)
  - ALU_NOP: DD, fun (2 bytes, 2 response bytes)
- SEND: TX_VALID=1 and TX_DATA = frame[index]. Index advances on each accept. TX_DATA and TX_VALID must not change while TX_VALID && !TX_READY.
- On the last byte accepted:
  - RF_WR goes to IDLE and pulses RSP_VALID with RSP_DATA=0.
  - Other commands go to WAIT_RSP with rx count 0 and timeout counter 0.
- WAIT_RSP, per RX_VALID:
  - The byte is stored and the timeout counter clears.
  - RF_RD: the first byte completes the command, with RSP_DATA={8'h00, byte}.
  - ALU commands: the first byte is the low half and the second the high half; RSP_DATA={second, first}.
  - On completion the state goes to IDLE and RSP_VALID pulses.
- Timeout: in WAIT_RSP, the counter increments on each cycle without RX_VALID. When the counter equals a nonzero TIMEOUT_LIMIT, the state goes to IDLE, RSP_TIMEOUT pulses, and RSP_DATA holds its previous value. The counter saturates and never wraps.
- RX_VALID outside WAIT_RSP is dropped. This includes the cycle in which the last TX byte is accepted.
- Extra RX bytes after completion are dropped (state is IDLE).

## Timing
- Reset values:
  - state IDLE, so CMD_READY=1 and BUSY=0
  - TX_VALID=0, TX_DATA=0
  - RSP_DATA=0, RSP_VALID=0, RSP_TIMEOUT=0
  - all counters 0
- RST asserted mid-command aborts immediately: no RSP pulse is produced and any partial response is discarded.
- Command accepted at edge N: TX_VALID=1 with byte 0 from cycle N+1. CMD_READY=0 from N+1.
- With TX_READY held high, one byte is sent per cycle. A 4-byte ALU_OP occupies SEND for exactly 4 cycles.
- Completing event at edge M (last TX accept, final RX byte, or limit reached): RSP_VALID or RSP_TIMEOUT is high during cycle M+1 only, with RSP_DATA valid in the same cycle. CMD_READY=1 and BUSY=0 also from M+1.
- A new command can be accepted at edge M+1.
- RSP_VALID and RSP_TIMEOUT are never high together.

## Test plan
- RF_WR, addr=5, data=0x3C, TX_READY=1:
  - TX bytes AA,05,3C on 3 consecutive cycles
  - RSP_VALID one cycle after the third accept, RSP_DATA=0x0000
- RF_RD, addr=2; drive RX 0x9A after 20 cycles:
  - TX bytes BB,02
  - RSP_DATA=0x009A, RSP_VALID one cycle after the RX strobe
- ALU_OP, A=0x12, B=0x34, fun=0; TX_READY toggling 1/0; RX 0x46 then 0x00:
  - TX bytes CC,12,34,00, with TX_DATA stable while stalled
  - RSP_DATA=0x0046
- ALU_NOP, fun=2, TIMEOUT_LIMIT=10; a single RX byte, then silence:
  - RSP_TIMEOUT pulses 10 cycles after the last RX strobe
  - no RSP_VALID; RSP_DATA unchanged
- Reset behaviour:
  - assert RST during SEND of ALU_OP after 2 bytes: all outputs reach reset values immediately
  - next RF_RD runs cleanly, starting from byte BB
  - RX_VALID pulsed while IDLE is ignored, with no RSP pulse
